// File: rtl/sync_ram_sdp_if.sv
// Bus bundle for sync_ram_sdp: clear control, byte-enabled write port and read port.
// The memory is the slave; whatever drives the ports uses the master view.
interface sync_ram_sdp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic                  clr_req;
    logic                  busy;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W/8-1:0]   wr_be;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;

    modport master (
        output clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  busy, rd_valid, rd_data
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output busy, rd_valid, rd_data
    );
endinterface

// File: rtl/sync_ram_sdp.sv
// Simple-dual-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write policy and a clear sweep run after reset or on request.
module sync_ram_sdp #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 3,
    parameter int                DEPTH      = 8,
    parameter int                RD_LATENCY = 1,
    parameter int                RDW_MODE   = 0,
    parameter logic [DATA_W-1:0] INIT_VAL   = '0
) (
    input logic         clk,
    input logic         rst_n,
    sync_ram_sdp_if.slave bus
);
    localparam int                BE_W      = DATA_W / 8;
    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [BE_W-1:0]     mem_be;
    logic [IDX_W-1:0]    mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic                wr_ok;
    logic                rd_acc;
    logic                rd_in_rng;
    logic [DATA_W-1:0]   rd_old;
    logic [DATA_W-1:0]   rd_word;

    logic                rd_vld_p1_q, rd_vld_p1_d;
    logic [DATA_W-1:0]   rd_data_p1_q, rd_data_p1_d;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Port accept: clr_req at an idle edge wins over any access sampled at that edge.
    always_comb begin
        wr_ok     = (state_q == ST_IDLE) && !bus.clr_req && bus.wr_en &&
                    ({1'b0, bus.wr_addr} < DEPTH_X);
        rd_acc    = (state_q == ST_IDLE) && !bus.clr_req && bus.rd_en;
        rd_in_rng = ({1'b0, bus.rd_addr} < DEPTH_X);
        rd_old    = rd_in_rng ? mem_q[bus.rd_addr[IDX_W-1:0]] : '0;
        rd_word   = rd_old;
        if (RDW_MODE == 1 && wr_ok && rd_in_rng && (bus.wr_addr == bus.rd_addr)) begin
            rd_word = merge_bytes(rd_old, bus.wr_data, bus.wr_be);
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_be     = '0;
        mem_wa     = '0;
        mem_wd     = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_be     = '1;
                mem_wa     = clr_addr_q[IDX_W-1:0];
                mem_wd     = INIT_VAL;
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) state_d = ST_IDLE;
            end
            default: begin
                if (bus.clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (wr_ok) begin
                    mem_we = 1'b1;
                    mem_be = bus.wr_be;
                    mem_wa = bus.wr_addr[IDX_W-1:0];
                    mem_wd = bus.wr_data;
                end
            end
        endcase
    end

    always_comb begin
        rd_vld_p1_d  = rd_acc;
        rd_data_p1_d = rd_acc ? rd_word : rd_data_p1_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) mem_q[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    // Stage p1: word sampled at the accepting edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            rd_vld_p1_q  <= 1'b0;
            rd_data_p1_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            rd_vld_p1_q  <= rd_vld_p1_d;
            rd_data_p1_q <= rd_data_p1_d;
        end
    end

    assign bus.busy = (state_q == ST_CLEAR);

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              rd_vld_p2_q, rd_vld_p2_d;
            logic [DATA_W-1:0] rd_data_p2_q, rd_data_p2_d;

            always_comb begin
                rd_vld_p2_d  = rd_vld_p1_q;
                rd_data_p2_d = rd_vld_p1_q ? rd_data_p1_q : rd_data_p2_q;
            end

            // Stage p2: optional output register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_vld_p2_q  <= 1'b0;
                    rd_data_p2_q <= '0;
                end else begin
                    rd_vld_p2_q  <= rd_vld_p2_d;
                    rd_data_p2_q <= rd_data_p2_d;
                end
            end

            assign bus.rd_valid = rd_vld_p2_q;
            assign bus.rd_data  = rd_data_p2_q;
        end else begin : g_lat1
            assign bus.rd_valid = rd_vld_p1_q;
            assign bus.rd_data  = rd_data_p1_q;
        end
    endgenerate
endmodule

// File: tb/tb_sync_ram_sdp.sv
// Directed bench for sync_ram_sdp: latency-1/old-data, latency-2/new-data and a DEPTH=6 instance.
module tb_sync_ram_sdp;
    logic        clk = 1'b0;
    logic        rst_n, rst_n_c;
    logic        clr_req, wr_en, rd_en;
    logic [2:0]  wr_addr, rd_addr;
    logic [1:0]  wr_be;
    logic [15:0] wr_data;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    sync_ram_sdp_if #(.DATA_W(16), .ADDR_W(3)) ifa (), ifb (), ifc ();

    assign ifa.clr_req = clr_req;  assign ifb.clr_req = clr_req;  assign ifc.clr_req = clr_req;
    assign ifa.wr_en   = wr_en;    assign ifb.wr_en   = wr_en;    assign ifc.wr_en   = wr_en;
    assign ifa.wr_addr = wr_addr;  assign ifb.wr_addr = wr_addr;  assign ifc.wr_addr = wr_addr;
    assign ifa.wr_be   = wr_be;    assign ifb.wr_be   = wr_be;    assign ifc.wr_be   = wr_be;
    assign ifa.wr_data = wr_data;  assign ifb.wr_data = wr_data;  assign ifc.wr_data = wr_data;
    assign ifa.rd_en   = rd_en;    assign ifb.rd_en   = rd_en;    assign ifc.rd_en   = rd_en;
    assign ifa.rd_addr = rd_addr;  assign ifb.rd_addr = rd_addr;  assign ifc.rd_addr = rd_addr;

    sync_ram_sdp #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RD_LATENCY(1), .RDW_MODE(0),
                   .INIT_VAL(16'hA5A5)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    sync_ram_sdp #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RD_LATENCY(2), .RDW_MODE(1),
                   .INIT_VAL(16'hA5A5)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    sync_ram_sdp #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .RD_LATENCY(1), .RDW_MODE(0),
                   .INIT_VAL(16'h5A5A)) u_c (.clk(clk), .rst_n(rst_n_c), .bus(ifc.slave));

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [1:0]  be;
        logic [15:0] wd;
        logic        re;
        logic [2:0]  ra;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; wr_be = '0; wr_data = '0; rd_addr = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle_in();
    endtask

    task automatic read_both(input string name, input logic [2:0] a, input logic [15:0] exp);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({name, "_a_vld"}, ifa.rd_valid, 1);
        chk({name, "_a_dat"}, ifa.rd_data, exp);
        tick();
        chk({name, "_b_vld"}, ifb.rd_valid, 1);
        chk({name, "_b_dat"}, ifb.rd_data, exp);
    endtask

    task automatic count_busy(input string name, input int exp_n, input int clr_at, input bit rd_during);
        int n = 0;
        rd_en = rd_during; rd_addr = 3'd2;
        while (ifa.busy && n < 40) begin
            clr_req = (n == clr_at);
            tick();
            n++;
            if (rd_during) begin
                chk($sformatf("%s_rdv_a%0d", name, n), ifa.rd_valid, 0);
                chk($sformatf("%s_rdv_b%0d", name, n), ifb.rd_valid, 0);
            end
        end
        clr_req = 1'b0; rd_en = 1'b0;
        chk(name, n, exp_n);
        chk({name, "_b_idle"}, ifb.busy, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd0, 16'hA5A5, 16'hA5A5};
        vecs[1]  = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd7, 16'hA5A5, 16'hA5A5};
        vecs[2]  = '{1'b1, 3'd3, 2'b11, 16'hBEEF, 1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 3'd3, 2'b01, 16'h1234, 1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd3, 16'hBE34, 16'hBE34};
        vecs[5]  = '{1'b1, 3'd5, 2'b11, 16'h1111, 1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b1, 3'd5, 2'b10, 16'h2222, 1'b1, 3'd5, 16'h1111, 16'h2211};
        vecs[7]  = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd5, 16'h2211, 16'h2211};
        vecs[8]  = '{1'b1, 3'd6, 2'b00, 16'hABCD, 1'b1, 3'd6, 16'hA5A5, 16'hA5A5};
        vecs[9]  = '{1'b1, 3'd2, 2'b11, 16'hCAFE, 1'b1, 3'd1, 16'hA5A5, 16'hA5A5};
        vecs[10] = '{1'b0, 3'd0, 2'b00, 16'h0000, 1'b1, 3'd2, 16'hCAFE, 16'hCAFE};

        idle_in();
        rst_n = 1'b0; rst_n_c = 1'b0;
        repeat (3) tick();
        chk("rst_busy_a", ifa.busy, 1);
        chk("rst_vld_a", ifa.rd_valid, 0);
        chk("rst_dat_a", ifa.rd_data, 0);
        chk("rst_vld_b", ifb.rd_valid, 0);
        chk("rst_dat_b", ifb.rd_data, 0);
        rst_n = 1'b1;
        count_busy("t1_busy", 8, -1, 1'b0);
        for (int k = 0; k < 8; k++) read_both($sformatf("t1_rd%0d", k), 3'(k), 16'hA5A5);

        for (int i = 0; i < 11; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_be = vecs[i].be; wr_data = vecs[i].wd;
            rd_en = vecs[i].re; rd_addr = vecs[i].ra;
            tick();
            idle_in();
            chk($sformatf("vec%0d_a_vld", i), ifa.rd_valid, vecs[i].re);
            if (vecs[i].re) chk($sformatf("vec%0d_a_dat", i), ifa.rd_data, vecs[i].exp_a);
            tick();
            chk($sformatf("vec%0d_a_off", i), ifa.rd_valid, 0);
            chk($sformatf("vec%0d_b_vld", i), ifb.rd_valid, vecs[i].re);
            if (vecs[i].re) chk($sformatf("vec%0d_b_dat", i), ifb.rd_data, vecs[i].exp_b);
        end

        // Back-to-back reads of 0..3
        for (int k = 0; k < 4; k++) write_word(3'(k), 16'h0010 + 16'(k), 2'b11);
        for (int k = 0; k < 6; k++) begin
            rd_en = (k < 4); rd_addr = 3'(k);
            tick();
            chk($sformatf("t3_a_vld%0d", k), ifa.rd_valid, (k < 4));
            if (k < 4) chk($sformatf("t3_a_dat%0d", k), ifa.rd_data, 16'h0010 + 16'(k));
            chk($sformatf("t3_b_vld%0d", k), ifb.rd_valid, (k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk($sformatf("t3_b_dat%0d", k), ifb.rd_data, 16'h000F + 16'(k));
        end
        chk("t3_a_hold", ifa.rd_data, 16'h0013);
        chk("t3_b_hold", ifb.rd_data, 16'h0013);

        // Clear request colliding with a write and a read
        for (int k = 0; k < 8; k++) write_word(3'(k), 16'hFFFF, 2'b11);
        read_both("t5_pre", 3'd4, 16'hFFFF);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd1;
        tick();
        idle_in();
        chk("t5_busy_on", ifa.busy, 1);
        chk("t5_rd_drop", ifa.rd_valid, 0);
        count_busy("t5_busy", 8, 3, 1'b1);
        for (int k = 0; k < 8; k++) read_both($sformatf("t5_rd%0d", k), 3'(k), 16'hA5A5);

        // Reset on the 4th busy cycle restarts the sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (3) tick();
        chk("t6_busy_mid", ifa.busy, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_busy", ifa.busy, 1);
        chk("t6_rst_dat_a", ifa.rd_data, 0);
        chk("t6_rst_dat_b", ifb.rd_data, 0);
        rst_n = 1'b1;
        count_busy("t6_busy", 8, -1, 1'b1);

        // DEPTH=6 instance: out-of-range access
        rst_n_c = 1'b1;
        n = 0;
        while (ifc.busy && n < 40) begin
            tick();
            n++;
        end
        chk("c_busy", n, 6);
        write_word(3'd7, 16'h1234, 2'b11);
        write_word(3'd5, 16'h0F0F, 2'b11);
        rd_en = 1'b1; rd_addr = 3'd7;
        tick();
        chk("c_oor_vld", ifc.rd_valid, 1);
        chk("c_oor_dat", ifc.rd_data, 0);
        rd_addr = 3'd5;
        tick();
        chk("c_rd5_vld", ifc.rd_valid, 1);
        chk("c_rd5_dat", ifc.rd_data, 16'h0F0F);
        rd_addr = 3'd4;
        tick();
        rd_en = 1'b0;
        chk("c_rd4_dat", ifc.rd_data, 16'h5A5A);
        tick();
        chk("c_rd_off", ifc.rd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
